dff_delay_line: RTL and testbench

Parametrised successor to the single-bit D flip-flop. It is a WIDTH-bit, DEPTH-stage register delay line with per-stage valid tracking, a clock enable (stall), a synchronous clear, a selectable tap and an occupancy counter. Datapath blocks use it for fixed-latency alignment of data and qualifier bits.

---
 rtl/dff_pkg.sv | 18 +
 rtl/dff_delay_line_if.sv | 39 +++
 rtl/dff_stage.sv | 31 +++
 rtl/dff_delay_line.sv | 88 ++++++++
 tb/tb_dff_delay_line.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/dff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pkg
//  Description : Shared defaults and width helper for the delay line.
//  Revision    : 1.0 - initial release
// ============================================================================
package dff_pkg;

  localparam int DFF_WIDTH_DEF = 8;
  localparam int DFF_DEPTH_DEF = 4;

  // Bits needed to index n items, never less than one so ports stay legal.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dff_delay_line_if.sv
`default_nettype none
// ============================================================================
//  Module      : dff_delay_line_if
//  Description : Control, data and tap bundle of the delay line.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dff_delay_line_if
  import dff_pkg::*;
#(
  parameter int WIDTH = DFF_WIDTH_DEF,
  parameter int DEPTH = DFF_DEPTH_DEF
) ();

  localparam int TSW = safe_clog2(DEPTH);
  localparam int OCW = safe_clog2(DEPTH + 1);

  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [TSW-1:0]   tap_sel;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [WIDTH-1:0] tap;
  logic             tap_valid;
  logic [OCW-1:0]   occupancy;

  modport master (
    output en, clr, d, d_valid, tap_sel,
    input  q, q_valid, tap, tap_valid, occupancy
  );

  modport slave (
    input  en, clr, d, d_valid, tap_sel,
    output q, q_valid, tap, tap_valid, occupancy
  );

endinterface
`default_nettype wire

// File: rtl/dff_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dff_stage
//  Description : One delay-line stage holding {valid, data}.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           clr,
  input  wire logic           en,
  input  wire logic [WIDTH:0] d,
  output logic      [WIDTH:0] q
);

  // Async reset, then clear over enable; the MSB is the valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {1'b0, RST_VAL};
    end else if (clr) begin
      q <= {1'b0, RST_VAL};
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dff_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : dff_delay_line
//  Description : DEPTH-stage WIDTH-bit delay line with valid tracking,
//                stall, clear, selectable tap and occupancy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_delay_line
  import dff_pkg::*;
#(
  parameter int               WIDTH   = DFF_WIDTH_DEF,
  parameter int               DEPTH   = DFF_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input wire logic         clk,
  input wire logic         rst,
  dff_delay_line_if.slave  bus
);

  localparam int OCW = safe_clog2(DEPTH + 1);

  logic [WIDTH:0]   stage_q [DEPTH];
  logic [OCW-1:0]   occ;
  logic [WIDTH-1:0] tap_data;
  logic             tap_vld;
  logic             out_valid;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        dff_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
          .clk (clk),
          .rst (rst),
          .clr (bus.clr),
          .en  (bus.en),
          .d   ({bus.d_valid, bus.d}),
          .q   (stage_q[i])
        );
      end else begin : g_body
        dff_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
          .clk (clk),
          .rst (rst),
          .clr (bus.clr),
          .en  (bus.en),
          .d   (stage_q[i-1]),
          .q   (stage_q[i])
        );
      end
    end
  endgenerate

  assign out_valid = stage_q[DEPTH-1][WIDTH];

  // Occupancy tracks the valid popcount: one word enters, one leaves per shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else if (bus.clr) begin
      occ <= '0;
    end else if (bus.en) begin
      if (bus.d_valid && !out_valid) begin
        occ <= occ + OCW'(1);
      end else if (!bus.d_valid && out_valid) begin
        occ <= occ - OCW'(1);
      end
    end
  end

  // Combinational tap; out-of-range selects fall back to the reset value.
  always_comb begin
    tap_data = RST_VAL;
    tap_vld  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(bus.tap_sel) == i) begin
        tap_data = stage_q[i][WIDTH-1:0];
        tap_vld  = stage_q[i][WIDTH];
      end
    end
  end

  assign bus.q         = stage_q[DEPTH-1][WIDTH-1:0];
  assign bus.q_valid   = out_valid;
  assign bus.tap       = tap_data;
  assign bus.tap_valid = tap_vld;
  assign bus.occupancy = occ;

endmodule
`default_nettype wire

// File: tb/tb_dff_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dff_delay_line
//  Description : Directed self-checking bench for dff_delay_line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_delay_line;

  logic clk;
  logic rst;
  logic rst3;
  int   checks;
  int   errors;

  dff_delay_line_if #(.WIDTH(8), .DEPTH(4)) bus_a ();
  dff_delay_line_if #(.WIDTH(8), .DEPTH(3)) bus_b ();

  dff_delay_line #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  dff_delay_line #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic e, input logic [7:0] dv, input logic v);
    bus_a.en = e; bus_a.d = dv; bus_a.d_valid = v;
    tick();
  endtask

  task automatic test_reset();
    push_a(1'b1, 8'h55, 1'b1);
    #3 rst = 1'b1;
    #1;
    checks++; if (bus_a.q !== 8'h00) begin errors++; $display("FAIL async_rst_q got %h exp 00", bus_a.q); end
    checks++; if (bus_a.q_valid !== 1'b0) begin errors++; $display("FAIL async_rst_qv got %b exp 0", bus_a.q_valid); end
    checks++; if (bus_a.occupancy !== 3'd0) begin errors++; $display("FAIL async_rst_occ got %0d exp 0", bus_a.occupancy); end
    checks++; if (bus_a.tap !== 8'h00 || bus_a.tap_valid !== 1'b0) begin errors++; $display("FAIL async_rst_tap got %h/%b exp 00/0", bus_a.tap, bus_a.tap_valid); end
    #1 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push_a(1'b1, 8'hA0 + 8'(k), 1'b1);
      checks++; if (bus_a.occupancy !== 3'(k)) begin errors++; $display("FAIL fill_occ edge %0d got %0d exp %0d", k, bus_a.occupancy, k); end
      if (k < 4) begin
        checks++; if (bus_a.q_valid !== 1'b0) begin errors++; $display("FAIL fill_qv edge %0d got %b exp 0", k, bus_a.q_valid); end
      end
    end
    checks++; if (bus_a.q !== 8'hA1 || bus_a.q_valid !== 1'b1) begin errors++; $display("FAIL fill_q got %h/%b exp a1/1", bus_a.q, bus_a.q_valid); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_q;
    for (int k = 1; k <= 8; k++) begin
      push_a(1'b1, 8'h10 + 8'(k - 1), 1'b1);
      exp_q = (k >= 4) ? 8'h10 + 8'(k - 4) : 8'hA1 + 8'(k);
      checks++; if (bus_a.q !== exp_q || bus_a.q_valid !== 1'b1) begin errors++; $display("FAIL stream_q edge %0d got %h/%b exp %h/1", k, bus_a.q, bus_a.q_valid, exp_q); end
      checks++; if (bus_a.occupancy !== 3'd4) begin errors++; $display("FAIL stream_occ edge %0d got %0d exp 4", k, bus_a.occupancy); end
    end
  endtask

  task automatic test_stall();
    bus_a.clr = 1'b1;
    push_a(1'b0, 8'h00, 1'b0);
    bus_a.clr = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push_a(1'b1, 8'h20 + 8'(k), 1'b1);
      checks++; if (bus_a.occupancy !== 3'(k) || bus_a.q_valid !== 1'b0) begin errors++; $display("FAIL stall_fill edge %0d got occ %0d qv %b exp %0d/0", k, bus_a.occupancy, bus_a.q_valid, k); end
    end
    bus_a.tap_sel = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      push_a(1'b0, 8'h99, 1'b1);
      checks++; if (bus_a.occupancy !== 3'd3 || bus_a.q_valid !== 1'b0 || bus_a.q !== 8'h00) begin errors++; $display("FAIL stall_hold edge %0d got occ %0d q %h/%b exp 3 00/0", k, bus_a.occupancy, bus_a.q, bus_a.q_valid); end
      checks++; if (bus_a.tap !== 8'h23) begin errors++; $display("FAIL stall_tap0 edge %0d got %h exp 23", k, bus_a.tap); end
    end
    push_a(1'b1, 8'h24, 1'b1);
    checks++; if (bus_a.q !== 8'h21 || bus_a.q_valid !== 1'b1 || bus_a.occupancy !== 3'd4) begin errors++; $display("FAIL stall_resume got %h/%b occ %0d exp 21/1 occ 4", bus_a.q, bus_a.q_valid, bus_a.occupancy); end
  endtask

  task automatic test_clear();
    bus_a.clr = 1'b1;
    push_a(1'b1, 8'hFF, 1'b1);
    bus_a.clr = 1'b0;
    checks++; if (bus_a.q !== 8'h00 || bus_a.q_valid !== 1'b0) begin errors++; $display("FAIL clr_q got %h/%b exp 00/0", bus_a.q, bus_a.q_valid); end
    checks++; if (bus_a.occupancy !== 3'd0) begin errors++; $display("FAIL clr_occ got %0d exp 0", bus_a.occupancy); end
    checks++; if (bus_a.tap !== 8'h00 || bus_a.tap_valid !== 1'b0) begin errors++; $display("FAIL clr_tap0 got %h/%b exp 00/0", bus_a.tap, bus_a.tap_valid); end
    for (int k = 0; k < 4; k++) begin
      bus_a.tap_sel = 2'(k);
      #1;
      checks++; if (bus_a.tap === 8'hFF) begin errors++; $display("FAIL clr_dropped stage %0d got %h exp not ff", k, bus_a.tap); end
    end
  endtask

  task automatic test_tap_pattern();
    logic [7:0] dv [4];
    logic       vv [4];
    logic [2:0] eo [4];
    dv = '{8'h31, 8'h32, 8'h33, 8'h34};
    vv = '{1'b1, 1'b0, 1'b1, 1'b1};
    eo = '{3'd1, 3'd1, 3'd2, 3'd3};
    for (int k = 0; k < 4; k++) begin
      push_a(1'b1, dv[k], vv[k]);
      checks++; if (bus_a.occupancy !== eo[k]) begin errors++; $display("FAIL pat_occ edge %0d got %0d exp %0d", k + 1, bus_a.occupancy, eo[k]); end
    end
    bus_a.tap_sel = 2'd1; #1;
    checks++; if (bus_a.tap !== 8'h33 || bus_a.tap_valid !== 1'b1) begin errors++; $display("FAIL tap_sel1 got %h/%b exp 33/1", bus_a.tap, bus_a.tap_valid); end
    bus_a.tap_sel = 2'd2; #1;
    checks++; if (bus_a.tap !== 8'h32 || bus_a.tap_valid !== 1'b0) begin errors++; $display("FAIL tap_sel2 got %h/%b exp 32/0", bus_a.tap, bus_a.tap_valid); end
    bus_a.tap_sel = 2'd3; #1;
    checks++; if (bus_a.tap !== 8'h31 || bus_a.tap_valid !== 1'b1) begin errors++; $display("FAIL tap_sel3 got %h/%b exp 31/1", bus_a.tap, bus_a.tap_valid); end
    push_a(1'b1, 8'h35, 1'b0);
    checks++; if (bus_a.occupancy !== 3'd2 || bus_a.q !== 8'h32 || bus_a.q_valid !== 1'b0) begin errors++; $display("FAIL pat_drain got occ %0d q %h/%b exp 2 32/0", bus_a.occupancy, bus_a.q, bus_a.q_valid); end
  endtask

  task automatic test_depth3();
    bus_b.en = 1'b1; bus_b.d_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus_b.d = 8'h40 + 8'(k);
      tick();
    end
    checks++; if (bus_b.q !== 8'h41 || bus_b.q_valid !== 1'b1 || bus_b.occupancy !== 2'd3) begin errors++; $display("FAIL d3_fill got %h/%b occ %0d exp 41/1 occ 3", bus_b.q, bus_b.q_valid, bus_b.occupancy); end
    bus_b.tap_sel = 2'd3; #1;
    checks++; if (bus_b.tap !== 8'h00 || bus_b.tap_valid !== 1'b0) begin errors++; $display("FAIL d3_tap_oor got %h/%b exp 00/0", bus_b.tap, bus_b.tap_valid); end
    bus_b.tap_sel = 2'd2; #1;
    checks++; if (bus_b.tap !== 8'h41 || bus_b.tap_valid !== 1'b1) begin errors++; $display("FAIL d3_tap2 got %h/%b exp 41/1", bus_b.tap, bus_b.tap_valid); end
    bus_b.d = 8'h44;
    tick();
    #3 rst3 = 1'b1;
    #1;
    checks++; if (bus_b.q !== 8'h00 || bus_b.q_valid !== 1'b0 || bus_b.occupancy !== 2'd0) begin errors++; $display("FAIL d3_rst got %h/%b occ %0d exp 00/0 occ 0", bus_b.q, bus_b.q_valid, bus_b.occupancy); end
    checks++; if (bus_b.tap !== 8'h00 || bus_b.tap_valid !== 1'b0) begin errors++; $display("FAIL d3_rst_tap got %h/%b exp 00/0", bus_b.tap, bus_b.tap_valid); end
    tick();
    checks++; if (bus_b.occupancy !== 2'd0 || bus_b.q_valid !== 1'b0) begin errors++; $display("FAIL d3_rst_hold got occ %0d qv %b exp 0/0", bus_b.occupancy, bus_b.q_valid); end
    rst3 = 1'b0;
    bus_b.en = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; rst3 = 1'b1;
    bus_a.en = 1'b0; bus_a.clr = 1'b0; bus_a.d = 8'h00; bus_a.d_valid = 1'b0; bus_a.tap_sel = 2'd0;
    bus_b.en = 1'b0; bus_b.clr = 1'b0; bus_b.d = 8'h00; bus_b.d_valid = 1'b0; bus_b.tap_sel = 2'd0;
    tick(); tick();
    rst = 1'b0; rst3 = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_clear();
    test_tap_pattern();
    test_depth3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
